// File: rtl/arb_pkg.sv
// Shared constants for the eight-way round-robin arbiter.
//   N_REQ    : number of requesters
//   IDX_W    : width of a requester index
//   HOLD_W   : width of the optional hold counter
//   ST_IDLE / ST_GRANT : arbiter state encoding
package arb_pkg;

    localparam int unsigned N_REQ  = 8;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned HOLD_W = 8;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

endpackage : arb_pkg

// File: rtl/decoder3_8.sv
// 3-to-8 one-hot decoder with enable.
//   i : binary index in
//   e : enable; output is all zeros when low
//   o : one-hot output
module decoder3_8 (
    input  logic [2:0] i,
    input  logic       e,
    output logic [7:0] o
);

    always_comb begin
        o = 8'h00;
        if (e) begin
            o = 8'h01 << i;
        end
    end

endmodule : decoder3_8

// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with grant-until-release ownership.
// The owner index is registered and decoded to a one-hot grant, enabled by busy.
//   clk     : clock, rising edge
//   rst     : synchronous active-high reset
//   req     : per-requester level request
//   done    : owner release strobe (ignored while idle)
//   gnt     : one-hot grant
//   gnt_idx : index of the current owner (valid while busy)
//   busy    : high while an owner holds the grant
//   timeout : one-cycle pulse after a forced release
// Optional feature: define ARB_TIMEOUT_EN to force a release after HOLD_MAX
// cycles of ownership; otherwise timeout is tied low and ownership is unbounded.
module rr_arbiter8
    import arb_pkg::*;
#(
    parameter int unsigned HOLD_MAX = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             busy,
    output logic             timeout
);

    if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_hold_range
        $error("rr_arbiter8: HOLD_MAX must be within 1..255");
    end

    // First set bit of cand, scanning upward from start with wrap; MSB = found.
    function automatic logic [IDX_W:0] rr_pick(input logic [N_REQ-1:0] cand,
                                               input logic [IDX_W-1:0] start);
        logic             found;
        logic [IDX_W-1:0] idx;
        logic [IDX_W-1:0] win;
        found = 1'b0;
        win   = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = start + IDX_W'(k);
            if (!found && cand[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        return {found, win};
    endfunction

    logic [0:0]       state_q,   state_d;
    logic [IDX_W-1:0] ptr_q,     ptr_d;
    logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;

    logic [IDX_W:0]   pick_idle;
    logic [IDX_W:0]   pick_rel;
    logic [IDX_W-1:0] rel_ptr;
    logic [N_REQ-1:0] cand_rel;
    logic             rel_by_owner;
    logic             expire;
    logic             release_ev;
    logic             new_grant;

    // Next-state, pointer and owner selection.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_idx_d = gnt_idx_q;
        new_grant = 1'b0;

        pick_idle    = rr_pick(req, ptr_q);
        rel_ptr      = gnt_idx_q + IDX_W'(1);
        // Outgoing owner is excluded so a release always hands off or idles.
        cand_rel     = req & ~gnt;
        pick_rel     = rr_pick(cand_rel, rel_ptr);
        rel_by_owner = done | ~req[gnt_idx_q];
        release_ev   = rel_by_owner | expire;

        case (state_q)
            ST_IDLE: begin
                if (pick_idle[IDX_W]) begin
                    state_d   = ST_GRANT;
                    gnt_idx_d = pick_idle[IDX_W-1:0];
                    new_grant = 1'b1;
                end
            end
            ST_GRANT: begin
                if (release_ev) begin
                    ptr_d = rel_ptr;
                    if (pick_rel[IDX_W]) begin
                        gnt_idx_d = pick_rel[IDX_W-1:0];
                        new_grant = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Arbiter state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            gnt_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_idx_q <= gnt_idx_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              timeout_q,  timeout_d;

    // Hold counter and forced-release pulse; a same-cycle owner release wins.
    always_comb begin
        hold_cnt_d = hold_cnt_q;
        timeout_d  = 1'b0;
        expire     = (state_q == ST_GRANT) && (hold_cnt_q == HOLD_W'(HOLD_MAX - 1));
        if (new_grant) begin
            hold_cnt_d = '0;
        end else if (state_q == ST_GRANT) begin
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
        if (expire && !rel_by_owner) begin
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign expire  = 1'b0;
    assign timeout = 1'b0;
`endif

    assign busy    = (state_q == ST_GRANT);
    assign gnt_idx = gnt_idx_q;

    decoder3_8 u_dec (
        .i (gnt_idx_q),
        .e (busy),
        .o (gnt)
    );

endmodule : rr_arbiter8
